// File: rtl/cache_fill_arbiter.sv
// Cache fill arbiter: grants I/D-cache misses (D has priority) and sequences an
// 8-word block fill over a pipelined memory with fixed return latency.
module cache_fill_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        icache_miss,
  input  logic        dcache_miss,
  input  logic [15:0] i_miss_addr,
  input  logic [15:0] d_miss_addr,
  input  logic        mem_data_valid,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [2:0]  fill_word,
  output logic        icache_data_wen,
  output logic        dcache_data_wen,
  output logic        icache_tag_wen,
  output logic        dcache_tag_wen,
  output logic        icache_fill_done,
  output logic        dcache_fill_done,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL_I = 2'd1,
    FILL_D = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] base_q, base_d;
  logic [3:0]  issue_q, issue_d;
  logic [3:0]  ret_q, ret_d;

  logic filling;
  logic issue_en;
  logic ret_en;
  logic last_ret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    filling  = (state_q != IDLE);
    issue_en = filling && (issue_q < 4'd8);
    ret_en   = filling && mem_data_valid;
    last_ret = ret_en && (ret_q == 4'd7);

    state_d = state_q;
    base_d  = base_q;
    issue_d = issue_q;
    ret_d   = ret_q;

    case (state_q)
      IDLE: begin
        if (dcache_miss) begin
          state_d = FILL_D;
          base_d  = d_miss_addr & 16'hFFF0;
        end else if (icache_miss) begin
          state_d = FILL_I;
          base_d  = i_miss_addr & 16'hFFF0;
        end
      end
      default: begin
        if (issue_en) issue_d = issue_q + 4'd1;
        if (ret_en)   ret_d   = ret_q + 4'd1;
        // The 8th return closes the fill; counters restart at zero for the next grant.
        if (last_ret) begin
          state_d = IDLE;
          issue_d = '0;
          ret_d   = '0;
        end
      end
    endcase
  end

  always_comb begin
    mem_en           = issue_en;
    mem_addr         = issue_en ? (base_q + {11'd0, issue_q, 1'b0}) : '0;
    fill_word        = ret_en ? ret_q[2:0] : '0;
    icache_data_wen  = ret_en && (state_q == FILL_I);
    dcache_data_wen  = ret_en && (state_q == FILL_D);
    icache_tag_wen   = last_ret && (state_q == FILL_I);
    dcache_tag_wen   = last_ret && (state_q == FILL_D);
    icache_fill_done = last_ret && (state_q == FILL_I);
    dcache_fill_done = last_ret && (state_q == FILL_D);
    busy             = filling;
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed + random bench for cache_fill_arbiter with a 4-cycle memory pipe and
// a scoreboard of expected issue addresses and data-write events.
module tb_cache_fill_arbiter;

  logic        clk;
  logic        rst;
  logic        icache_miss, dcache_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        mem_data_valid;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [2:0]  fill_word;
  logic        icache_data_wen, dcache_data_wen;
  logic        icache_tag_wen, dcache_tag_wen;
  logic        icache_fill_done, dcache_fill_done;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ret_seen = 0;
  int last_done_cyc = -1;

  logic [3:0] pipe;
  logic       spur;

  typedef struct {
    logic       is_d;
    logic [2:0] word;
    logic       last;
  } wen_t;

  logic [15:0] exp_addr[$];
  wen_t        exp_wen[$];

  cache_fill_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .dcache_miss      (dcache_miss),
    .i_miss_addr      (i_miss_addr),
    .d_miss_addr      (d_miss_addr),
    .mem_data_valid   (mem_data_valid),
    .mem_en           (mem_en),
    .mem_addr         (mem_addr),
    .fill_word        (fill_word),
    .icache_data_wen  (icache_data_wen),
    .dcache_data_wen  (dcache_data_wen),
    .icache_tag_wen   (icache_tag_wen),
    .dcache_tag_wen   (dcache_tag_wen),
    .icache_fill_done (icache_fill_done),
    .dcache_fill_done (dcache_fill_done),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: each issued read returns exactly four cycles later.
  always @(posedge clk or negedge rst) begin
    if (!rst) pipe <= '0;
    else      pipe <= {pipe[2:0], mem_en};
  end
  assign mem_data_valid = pipe[3] | spur;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {5'd0, mem_en, mem_addr, fill_word, icache_data_wen, dcache_data_wen,
              icache_tag_wen, dcache_tag_wen, icache_fill_done, dcache_fill_done, busy}, 32'd0);
  endtask

  task automatic push_fill(input logic is_d, input logic [15:0] addr);
    logic [15:0] base;
    wen_t w;
    base = addr & 16'hFFF0;
    for (int unsigned i = 0; i < 8; i++) begin
      exp_addr.push_back(base + 16'(2 * i));
      w.is_d = is_d;
      w.word = 3'(i);
      w.last = (i == 7);
      exp_wen.push_back(w);
    end
  endtask

  task automatic wait_idle(input string tag);
    logic ok;
    ok = 1'b0;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk);
      if (!busy && exp_addr.size() == 0 && exp_wen.size() == 0) ok = 1'b1;
    end
    chk(tag, {31'd0, ok}, 32'd1);
  endtask

  // Scoreboard monitor: compares every issue and every data write against the queues.
  always @(negedge clk) begin
    if (rst) begin
      if (mem_en) begin
        chk("issue_expected", {31'd0, exp_addr.size() != 0}, 32'd1);
        if (exp_addr.size() != 0) chk("mem_addr", {16'd0, mem_addr}, {16'd0, exp_addr.pop_front()});
      end
      if (icache_data_wen || dcache_data_wen) begin
        wen_t w;
        ret_seen++;
        chk("wen_expected", {31'd0, exp_wen.size() != 0}, 32'd1);
        if (exp_wen.size() != 0) begin
          w = exp_wen.pop_front();
          chk("wen_event",
              {23'd0, icache_data_wen, dcache_data_wen, fill_word, icache_tag_wen, dcache_tag_wen,
               icache_fill_done, dcache_fill_done},
              {23'd0, !w.is_d, w.is_d, w.word, w.last && !w.is_d, w.last && w.is_d,
               w.last && !w.is_d, w.last && w.is_d});
        end
      end else begin
        chk("no_tag_done_without_wen",
            {28'd0, icache_tag_wen, dcache_tag_wen, icache_fill_done, dcache_fill_done}, 32'd0);
      end
      if (icache_fill_done || dcache_fill_done) last_done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int g;
    int start;
    logic seen;
    int r;

    rst = 1'b0; spur = 1'b0;
    icache_miss = 1'b0; dcache_miss = 1'b0;
    i_miss_addr = '0; d_miss_addr = '0;
    #3;
    chk_all_zero("reset_state");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    // I-only fill with latency check
    i_miss_addr = 16'h1236; icache_miss = 1'b1;
    push_fill(1'b0, 16'h1236);
    g = cyc + 1;
    @(negedge clk);
    chk("i_grant_busy", {31'd0, busy}, 32'd1);
    icache_miss = 1'b0;
    wait_idle("i_fill_complete");
    chk("fill_latency", 32'(last_done_cyc - g + 1), 32'd12);

    // Spurious returns in IDLE
    @(negedge clk);
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("spurious_idle", {28'd0, busy, icache_data_wen, dcache_data_wen,
                            icache_fill_done | dcache_fill_done}, 32'd0);
    end
    @(negedge clk);
    spur = 1'b0;

    // Simultaneous misses: D first, then I after exactly one IDLE cycle
    @(negedge clk);
    d_miss_addr = 16'h8004; i_miss_addr = 16'h2A5C;
    dcache_miss = 1'b1; icache_miss = 1'b1;
    push_fill(1'b1, 16'h8004);
    push_fill(1'b0, 16'h2A5C);
    @(negedge clk);
    dcache_miss = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (dcache_fill_done) seen = 1'b1;
    end
    chk("d_done_seen", {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk("idle_gap_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("i_after_gap", {30'd0, busy, mem_en}, 32'd3);
    icache_miss = 1'b0;
    wait_idle("d_then_i_complete");

    // Granted miss dropped and address changed mid-fill
    @(negedge clk);
    d_miss_addr = 16'h9ABE; dcache_miss = 1'b1;
    push_fill(1'b1, 16'h9ABE);
    repeat (4) @(negedge clk);
    d_miss_addr = 16'h4000; dcache_miss = 1'b0;
    wait_idle("d_fill_unaffected");

    // Asynchronous reset after the 5th return, pending I miss refills from word 0
    @(negedge clk);
    i_miss_addr = 16'h3456; icache_miss = 1'b1;
    push_fill(1'b0, 16'h3456);
    start = ret_seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk); #1;
      if (ret_seen >= start + 5) seen = 1'b1;
    end
    chk("five_returns_seen", {31'd0, seen}, 32'd1);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_reset_outputs");
    exp_addr.delete();
    exp_wen.delete();
    @(negedge clk);
    chk_all_zero("reset_held");
    push_fill(1'b0, 16'h3456);
    rst = 1'b1;
    @(negedge clk);
    chk("refill_word0_issue", {15'd0, mem_en, mem_addr}, {15'd0, 1'b1, 16'h3450});
    icache_miss = 1'b0;
    wait_idle("refill_complete");

    // Random miss sequences
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 2);
      i_miss_addr = 16'($urandom);
      d_miss_addr = 16'($urandom);
      icache_miss = (r != 1);
      dcache_miss = (r != 0);
      if (r != 0) push_fill(1'b1, d_miss_addr);
      else        push_fill(1'b0, i_miss_addr);
      @(negedge clk);
      icache_miss = 1'b0;
      dcache_miss = 1'b0;
      i_miss_addr = 16'($urandom);
      d_miss_addr = 16'($urandom);
      wait_idle("random_fill_complete");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
